// File: rtl/div_pkg.sv
// Shared definitions for the divider result queue.
// The default operand width and the packed result entry {err, q, r} live here.
package div_pkg;

  // Default quotient/remainder width; matches the divider datapath.
  localparam int DIV_WIDTH = 4;

  // One divider result as it is stored in the queue.
  typedef struct packed {
    logic                 err;
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] r;
  } div_res_t;

  // Width of one packed entry for an arbitrary operand width.
  function automatic int entry_bits(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/div_res_ram.sv
// Storage array for the divider result queue.
// One synchronous write port and one asynchronous (combinational) read port.
module div_res_ram #(
  parameter int DW    = 9,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  // NOTE: the array has no reset; occupancy is tracked by the pointers and
  // the count, so stale contents are never presented and no reset tree is spent.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/div_result_fifo.sv
// Result queue that sits behind a multi-cycle divider.
// Captures {error, q, r} on each rising edge of the divider's done level,
// presents the oldest entry with valid/ready handshaking, and flags drops.
// Optional statistics outputs are enabled with the DIV_RESULT_STATS_EN macro.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         q,
  input  logic [WIDTH-1:0]         r,
  input  logic                     error,
  input  logic                     done,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_q,
  output logic [WIDTH-1:0]         out_r,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
`ifdef DIV_RESULT_STATS_EN
  output logic [7:0]               res_cnt,
  output logic [7:0]               err_cnt,
`endif
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = entry_bits(WIDTH);

  logic          r_done_d;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_overflow;
  logic          w_capture;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;
  logic          w_full;
  logic          w_valid;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_capture = done & ~r_done_d;
  assign w_pop     = w_valid & out_ready & ~flush;
  // A capture into a full queue still lands when the head leaves on the same edge.
  assign w_write   = w_capture & ~flush & (~w_full | w_pop);
  assign w_drop    = w_capture & ~flush & w_full & ~w_pop;
  assign w_wdata   = {error, q, r};

  div_res_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Delayed done for edge detection; held high in reset so a level that is
  // already high at reset release is not mistaken for a new result.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_d <= 1'b1;
    end else begin
      r_done_d <= done;
    end
  end

  // Next occupancy from the write/pop combination.
  // NOTE: the combinational block assigns its output a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    if (w_write && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_write && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Pointers and count; flush empties the queue ahead of any write or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Sticky drop flag, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef DIV_RESULT_STATS_EN
  logic [7:0] r_res_cnt;
  logic [7:0] r_err_cnt;

  // Accepted-result counter wraps; error counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_cnt <= '0;
      r_err_cnt <= '0;
    end else if (flush) begin
      r_res_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_write) begin
      r_res_cnt <= r_res_cnt + 8'd1;
      if (error && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign res_cnt = r_res_cnt;
  assign err_cnt = r_err_cnt;
`endif

  // Head entry is forced to zero while the queue is empty.
  assign out_valid = w_valid;
  assign out_err   = w_valid & w_rdata[DW-1];
  assign out_q     = w_valid ? w_rdata[2*WIDTH-1:WIDTH] : '0;
  assign out_r     = w_valid ? w_rdata[WIDTH-1:0]       : '0;
  assign count     = r_count;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule
